uart_tx_arbiter: RTL

- Shares one Uart8Transmitter between NUM_REQ byte-stream requesters in the system clock domain.
- Round-robin arbitration; a requester may lock the transmitter for a multi-byte frame using reqLast.
- Sequences txStart against the transmitter's slow baud-clock domain by synchronising txBusy.
- Supervises each hand-off with a timeout.
- Sits between client logic and the transmitter ports (txStart, in, txBusy) of Uart8.

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for uart_tx_arbiter.
// The master side is the client logic plus the transmitter; the slave side is the arbiter.
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      reqValid;
  logic [NUM_REQ-1:0][7:0] reqData;
  logic [NUM_REQ-1:0]      reqLast;
  logic [NUM_REQ-1:0]      reqReady;
  logic                    txStart;
  logic [7:0]              txData;
  logic                    txBusy;
  logic                    grantValid;
  logic [IW-1:0]           grantId;
  logic                    errPulse;

  modport master (
    output reqValid, reqData, reqLast, txBusy,
    input  reqReady, txStart, txData, grantValid, grantId, errPulse
  );
  modport slave (
    input  reqValid, reqData, reqLast, txBusy,
    output reqReady, txStart, txData, grantValid, grantId, errPulse
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART byte transmitter among NUM_REQ requesters.
// A requester keeps the grant across a frame until it sends a byte with reqLast set.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic             clk,
  input logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW   = $clog2(NUM_REQ);
  localparam int CMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {ARB, LOAD, START, SEND, GAP, HOLD} state_t;

  state_t        state, state_n;
  logic          busy_meta, busy_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] last_grant, last_grant_n, grant_id_n, winner, idx;
  logic          lock, lock_n, tx_start_n, grant_valid_n, err_n, found;
  logic [7:0]    tx_data_n;

  // Search order starts just after the previous winner, wrapping at NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = last_grant;
    idx    = last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      if (!found && bus.reqValid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    bus.reqReady = '0;
    if (state == LOAD) bus.reqReady[bus.grantId] = 1'b1;
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    lock_n        = lock;
    last_grant_n  = last_grant;
    tx_start_n    = bus.txStart;
    tx_data_n     = bus.txData;
    grant_valid_n = bus.grantValid;
    grant_id_n    = bus.grantId;
    err_n         = 1'b0;
    unique case (state)
      ARB: begin
        grant_valid_n = 1'b0;
        if (found) begin
          grant_id_n    = winner;
          grant_valid_n = 1'b1;
          last_grant_n  = winner;
          state_n       = LOAD;
        end
      end
      LOAD: begin
        tx_data_n  = bus.reqData[bus.grantId];
        lock_n     = ~bus.reqLast[bus.grantId];
        tx_start_n = 1'b1;
        cnt_n      = '0;
        state_n    = START;
      end
      START: begin
        if (busy_s) begin
          tx_start_n = 1'b0;
          cnt_n      = '0;
          state_n    = SEND;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          // Transmitter never acknowledged; the byte is dropped, not retried.
          tx_start_n    = 1'b0;
          err_n         = 1'b1;
          lock_n        = 1'b0;
          grant_valid_n = 1'b0;
          cnt_n         = '0;
          state_n       = ARB;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SEND: begin
        if (!busy_s) begin
          cnt_n   = '0;
          state_n = GAP;
        end
      end
      GAP: begin
        if (int'(cnt) + 1 >= GAP_CYCLES) begin
          cnt_n = '0;
          if (lock) state_n = HOLD;
          else begin
            grant_valid_n = 1'b0;
            state_n       = ARB;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (bus.reqValid[bus.grantId]) begin
          cnt_n   = '0;
          state_n = LOAD;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          err_n         = 1'b1;
          lock_n        = 1'b0;
          grant_valid_n = 1'b0;
          cnt_n         = '0;
          state_n       = ARB;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_meta      <= 1'b0;
      busy_s         <= 1'b0;
      state          <= ARB;
      cnt            <= '0;
      last_grant     <= IW'(NUM_REQ - 1);
      lock           <= 1'b0;
      bus.txStart    <= 1'b0;
      bus.txData     <= '0;
      bus.grantValid <= 1'b0;
      bus.grantId    <= '0;
      bus.errPulse   <= 1'b0;
    end else begin
      busy_meta      <= bus.txBusy;
      busy_s         <= busy_meta;
      state          <= state_n;
      cnt            <= cnt_n;
      last_grant     <= last_grant_n;
      lock           <= lock_n;
      bus.txStart    <= tx_start_n;
      bus.txData     <= tx_data_n;
      bus.grantValid <= grant_valid_n;
      bus.grantId    <= grant_id_n;
      bus.errPulse   <= err_n;
    end
  end
endmodule
